// File: rtl/hvsync_timing_gen_if.sv
// Raster timing bundle: run request toward the generator, pixel strobe, position, syncs and markers back.
// The generator drives through master; pixel-generation logic consumes through slave.
interface hvsync_timing_gen_if #(
  parameter int H_BITS = 10,
  parameter int V_BITS = 10
);
  logic              run;
  logic              pix_en;
  logic [H_BITS-1:0] hpos;
  logic [V_BITS-1:0] vpos;
  logic              hsync;
  logic              vsync;
  logic              display_on;
  logic              line_start;
  logic              frame_start;

  modport master (
    input  run,
    output pix_en, hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );

  modport slave (
    output run,
    input  pix_en, hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );
endinterface

// File: rtl/hvsync_timing_gen.sv
// Raster timing generator on the system clock with a pixel clock-enable; all decodes registered with zero skew to hpos/vpos.
// No backpressure: run=0 freezes position and masks markers while the pixel divider keeps running.
module hvsync_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int H_BITS    = 10,
  parameter int V_BITS    = 10
) (
  input  logic clk,
  input  logic reset,
  hvsync_timing_gen_if.master vid
);

  localparam int H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_BEG  = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END  = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG  = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END  = V_SYNC_BEG + V_SYNC;
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
  localparam logic HS_ON  = (HSYNC_POL != 0);
  localparam logic HS_OFF = !HS_ON;
  localparam logic VS_ON  = (VSYNC_POL != 0);
  localparam logic VS_OFF = !VS_ON;

  if (CLK_DIV < 1 || H_SYNC < 1 || V_SYNC < 1 ||
      H_TOTAL > (1 << H_BITS) || V_TOTAL > (1 << V_BITS)) begin : g_bad_cfg
    $error("hvsync_timing_gen: illegal configuration");
  end

  logic [DIV_W-1:0]  div_cnt, div_next;
  logic              pix_en_q, pix_en_next;
  logic [H_BITS-1:0] hpos_q, hpos_next;
  logic [V_BITS-1:0] vpos_q, vpos_next;
  logic              hsync_q, hsync_next;
  logic              vsync_q, vsync_next;
  logic              de_q, de_next;
  logic              ls_q, ls_next;
  logic              fs_q, fs_next;
  logic              adv;

  always_comb begin
    div_next    = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    // pix_en is high in the cycle that ends on the edge where div_cnt wraps
    pix_en_next = (div_next == DIV_LAST);
    adv         = pix_en_q & vid.run;
    hpos_next   = hpos_q;
    vpos_next   = vpos_q;
    if (adv) begin
      if (hpos_q == H_LAST) begin
        hpos_next = '0;
        vpos_next = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end else begin
        hpos_next = hpos_q + 1'b1;
      end
    end
    hsync_next = (int'(hpos_next) >= H_SYNC_BEG && int'(hpos_next) < H_SYNC_END) ? HS_ON : HS_OFF;
    vsync_next = (int'(vpos_next) >= V_SYNC_BEG && int'(vpos_next) < V_SYNC_END) ? VS_ON : VS_OFF;
    de_next    = (int'(hpos_next) < H_DISPLAY) && (int'(vpos_next) < V_DISPLAY);
    ls_next    = pix_en_next && (hpos_next == '0);
    fs_next    = ls_next && (vpos_next == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      pix_en_q <= 1'b0;
      hpos_q   <= '0;
      vpos_q   <= '0;
      hsync_q  <= HS_OFF;
      vsync_q  <= VS_OFF;
      de_q     <= 1'b1;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      pix_en_q <= pix_en_next;
      hpos_q   <= hpos_next;
      vpos_q   <= vpos_next;
      hsync_q  <= hsync_next;
      vsync_q  <= vsync_next;
      de_q     <= de_next;
      ls_q     <= ls_next;
      fs_q     <= fs_next;
    end
  end

  // Markers are qualified by the live run so a frozen position never emits them
  assign vid.pix_en      = pix_en_q;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.display_on  = de_q;
  assign vid.line_start  = ls_q & vid.run;
  assign vid.frame_start = fs_q & vid.run;

endmodule

// File: tb/tb_hvsync_timing_gen.sv
// Bench for hvsync_timing_gen: small raster with a pixel-index scoreboard plus decode table, and a CLK_DIV=1 VGA line check.
module tb_hvsync_timing_gen;
  localparam int D  = 2;
  localparam int HD = 8, HF = 2, HS = 2, HB = 2, HT = 14;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1, VT = 7;
  localparam int HP = 0, VP = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  hvsync_timing_gen_if #(.H_BITS(4), .V_BITS(3))   vid ();
  hvsync_timing_gen_if #(.H_BITS(10), .V_BITS(10)) vga ();

  hvsync_timing_gen #(
    .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .H_BITS(4), .V_BITS(3)
  ) dut (.clk(clk), .reset(rst), .vid(vid));

  hvsync_timing_gen #(.CLK_DIV(1)) dut_vga (.clk(clk), .reset(rst2), .vid(vga));

  typedef struct packed {
    logic       pix_en;
    logic [3:0] hpos;
    logic [2:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
  } obs_t;

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic de;
  } vec_t;

  obs_t sb_q[$];
  vec_t tbl[13];
  int n_cmp = 0, n_bad = 0;
  int n_e = 0, p_cnt = 0;
  int de_pix, ls_cnt, fs_cnt, hs_lo, vs_hi;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_pix(input int n);
    return (n >= 1) && (((n + 1) % D) == 0);
  endfunction

  // Expected outputs from the absolute count of counted pixels since release
  function automatic obs_t model_obs();
    obs_t o;
    int h, v;
    h = p_cnt % HT;
    v = (p_cnt / HT) % VT;
    o.pix_en      = model_pix(n_e);
    o.hpos        = 4'(h);
    o.vpos        = 3'(v);
    o.hsync       = (h >= HD + HF && h < HD + HF + HS) ? 1'(HP) : !1'(HP);
    o.vsync       = (v >= VD + VF && v < VD + VF + VS) ? 1'(VP) : !1'(VP);
    o.display_on  = (h < HD) && (v < VD);
    o.line_start  = o.pix_en && vid.run && (h == 0);
    o.frame_start = o.line_start && (v == 0);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pix_en = vid.pix_en; o.hpos = vid.hpos; o.vpos = vid.vpos;
    o.hsync = vid.hsync; o.vsync = vid.vsync; o.display_on = vid.display_on;
    o.line_start = vid.line_start; o.frame_start = vid.frame_start;
    return o;
  endfunction

  task automatic clear_stats();
    de_pix = 0; ls_cnt = 0; fs_cnt = 0; hs_lo = 0; vs_hi = 0;
  endtask

  task automatic tick();
    obs_t a, e;
    @(posedge clk);
    if (!rst) begin
      if (model_pix(n_e) && vid.run) p_cnt++;
      n_e++;
    end
    #1;
    sb_q.push_back(model_obs());
    #1;
    a = dut_obs();
    e = sb_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL scoreboard t=%0t actual pix=%b h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b required pix=%b h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
               $time, a.pix_en, a.hpos, a.vpos, a.hsync, a.vsync, a.display_on, a.line_start, a.frame_start,
               e.pix_en, e.hpos, e.vpos, e.hsync, e.vsync, e.display_on, e.line_start, e.frame_start);
    end
    if (a.pix_en && a.display_on) de_pix++;
    if (a.line_start) ls_cnt++;
    if (a.frame_start) fs_cnt++;
    if (!a.hsync) hs_lo++;
    if (a.vsync) vs_hi++;
  endtask

  task automatic wait_pos(input string nm, input int h, input int v, output bit ok);
    int k = 0;
    while (!(int'(vid.hpos) == h && int'(vid.vpos) == v) && k < 400) begin
      tick();
      k++;
    end
    ok = (k < 400);
    if (!ok) check({nm, "_reach"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int held_h, held_v, held_hs, held_de, mk, k;
    int low_pix, hs_first, hs_low, ls1, ls2, fs_v, v_at;

    tbl[0]  = '{0, 0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{8, 0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{10, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{9, 1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{11, 2, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{7, 3, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{12, 3, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{0, 4, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{13, 4, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3, 5, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{10, 5, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{0, 6, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{13, 6, 1'b1, 1'b0, 1'b0};

    vid.run = 1'b1;
    vga.run = 1'b1;
    clear_stats();
    repeat (2) tick();
    check("rst_hpos", vid.hpos, 0);
    check("rst_vpos", vid.vpos, 0);
    check("rst_pix_en", vid.pix_en, 0);
    check("rst_hsync", vid.hsync, 1);
    check("rst_vsync", vid.vsync, 0);
    check("rst_display_on", vid.display_on, 1);

    // First frame after release
    rst = 1'b0;
    clear_stats();
    tick();
    check("edge1_pix_en", vid.pix_en, 1);
    check("edge1_frame_start", vid.frame_start, 1);
    tick();
    check("edge2_pix_en", vid.pix_en, 0);
    check("edge2_hpos", vid.hpos, 1);
    repeat (194) tick();
    check("frame_de_pixels", de_pix, 32);
    check("frame_line_starts", ls_cnt, 7);
    check("frame_frame_starts", fs_cnt, 1);
    check("frame_hsync_low_clks", hs_lo, 28);
    check("frame_vsync_high_clks", vs_hi, 28);
    check("frame_wrap_hpos", vid.hpos, 0);
    check("frame_wrap_vpos", vid.vpos, 0);
    tick();
    check("frame_period_196", vid.frame_start, 1);

    foreach (tbl[i]) begin
      wait_pos($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, ok);
      if (ok) begin
        check($sformatf("tbl%0d_hsync", i), vid.hsync, tbl[i].hs);
        check($sformatf("tbl%0d_vsync", i), vid.vsync, tbl[i].vs);
        check($sformatf("tbl%0d_display_on", i), vid.display_on, tbl[i].de);
      end
    end

    // Freeze at (5,2) for 10 clks
    wait_pos("freeze", 5, 2, ok);
    held_h = vid.hpos; held_v = vid.vpos; held_hs = vid.hsync; held_de = vid.display_on;
    vid.run = 1'b0;
    mk = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      mk += int'(vid.line_start) + int'(vid.frame_start);
    end
    check("freeze_hpos", vid.hpos, 5);
    check("freeze_vpos", vid.vpos, 2);
    check("freeze_hsync", vid.hsync, held_hs);
    check("freeze_display_on", vid.display_on, held_de);
    check("freeze_markers", mk, 0);
    vid.run = 1'b1;
    k = 0;
    while (!vid.pix_en && k < 4) begin tick(); k++; end
    tick();
    check("resume_hpos", vid.hpos, 6);
    check("resume_vpos", vid.vpos, 2);

    // Asynchronous reset while hsync is active
    wait_pos("areset", 11, 0, ok);
    check("areset_pre_hsync", vid.hsync, 0);
    #3;
    rst = 1'b1;
    n_e = 0;
    p_cnt = 0;
    #1;
    check("areset_hsync", vid.hsync, 1);
    check("areset_hpos", vid.hpos, 0);
    check("areset_vpos", vid.vpos, 0);
    check("areset_pix_en", vid.pix_en, 0);
    repeat (2) tick();
    rst = 1'b0;
    clear_stats();
    tick();
    check("recover_pix_en", vid.pix_en, 1);
    check("recover_frame_start", vid.frame_start, 1);
    repeat (195) tick();
    check("recover_frame_starts", fs_cnt, 1);
    check("recover_de_pixels", de_pix, 32);
    check("recover_wrap_vpos", vid.vpos, 0);

    // VGA defaults with CLK_DIV=1
    low_pix = 0; hs_first = -1; hs_low = 0; ls1 = -1; ls2 = -1; fs_v = 0; v_at = -1;
    @(posedge clk); #2;
    rst2 = 1'b0;
    for (int c = 1; c <= 1700; c++) begin
      @(posedge clk); #1;
      if (!vga.pix_en) low_pix++;
      if (!vga.hsync) begin
        if (hs_first < 0) hs_first = vga.hpos;
        if (c <= 800) hs_low++;
      end
      if (vga.line_start) begin
        if (ls1 < 0) ls1 = c;
        else if (ls2 < 0) ls2 = c;
      end
      if (vga.frame_start) fs_v++;
      if (c == 801) v_at = vga.vpos;
    end
    check("vga_pix_en_low_clks", low_pix, 0);
    check("vga_hsync_start_hpos", hs_first, 656);
    check("vga_hsync_low_clks", hs_low, 96);
    check("vga_first_line_start", ls1, 1);
    check("vga_line_period", ls2 - ls1, 800);
    check("vga_vpos_after_line", v_at, 1);
    check("vga_frame_starts", fs_v, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
